facelet_sample_ctrl: RTL

// Sequences one face capture for the cube colour pipeline. On Start it latches the detected cube

---
 rtl/facelet_pkg.sv | 24 ++
 rtl/facelet_offset_calc.sv | 43 ++++
 rtl/facelet_sample_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/facelet_pkg.sv
// Shared types and constants for the facelet sampling block.
package facelet_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    WAIT_FRAME,
    SCAN,
    EMIT
  } state_t;

  localparam int unsigned NUM_FACELETS = 9;
  localparam logic [3:0]  LAST_INDEX   = 4'(NUM_FACELETS - 1);

  // Channel width of stored samples; the top's PIX_W is expected to match.
  localparam int unsigned RGB_W = 10;

  typedef struct packed {
    logic [RGB_W-1:0] R;
    logic [RGB_W-1:0] G;
    logic [RGB_W-1:0] B;
  } rgb_t;

endpackage

// File: rtl/facelet_offset_calc.sv
// Registers the three facelet centre offsets N/6, N/2 and 5N/6 from the cube side.
module facelet_offset_calc #(
  parameter int unsigned SIDE_W = 10
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              load,
  input  logic [SIDE_W-1:0] N,
  output logic [SIDE_W-1:0] off1,
  output logic [SIDE_W-1:0] off2,
  output logic [SIDE_W-1:0] off3
);

  localparam logic [SIDE_W+2:0] DIV6 = (SIDE_W+3)'(6);
  localparam logic [SIDE_W+2:0] MUL5 = (SIDE_W+3)'(5);

  logic [SIDE_W+2:0] n_ext;
  logic [SIDE_W+2:0] n5;
  logic [SIDE_W+2:0] q1;
  logic [SIDE_W+2:0] q3;

  // Constant divides; 5*N is carried in SIDE_W+3 bits so it cannot overflow.
  always_comb begin
    n_ext = {3'b000, N};
    n5    = n_ext * MUL5;
    q1    = n_ext / DIV6;
    q3    = n5 / DIV6;
  end

  // Offsets are captured together with the cube geometry and valid one cycle later.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      off1 <= '0;
      off2 <= '0;
      off3 <= '0;
    end else if (load) begin
      off1 <= SIDE_W'(q1);
      off2 <= N >> 1;
      off3 <= SIDE_W'(q3);
    end
  end

endmodule

// File: rtl/facelet_sample_ctrl.sv
// Captures the RGB value at each of the 9 facelet centres over one frame and streams them out.
module facelet_sample_ctrl
  import facelet_pkg::*;
#(
  parameter int unsigned COORD_W = 11,
  parameter int unsigned SIDE_W  = 10,
  parameter int unsigned PIX_W   = 10
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic [COORD_W-1:0] CubeX_Start,
  input  logic [COORD_W-1:0] CubeY_Start,
  input  logic [SIDE_W-1:0]  N,
  input  logic               iFrameStart,
  input  logic               iPixValid,
  input  logic [COORD_W-1:0] iX,
  input  logic [COORD_W-1:0] iY,
  input  logic [PIX_W-1:0]   iR,
  input  logic [PIX_W-1:0]   iG,
  input  logic [PIX_W-1:0]   iB,
  output logic               oValid,
  input  logic               oReady,
  output logic [3:0]         oIndex,
  output logic [PIX_W-1:0]   oR,
  output logic [PIX_W-1:0]   oG,
  output logic [PIX_W-1:0]   oB,
  output logic               Busy,
  output logic               Done,
  output logic               Error
);

  state_t state, state_nxt;

  logic [COORD_W-1:0]      x_q, y_q;
  logic [SIDE_W-1:0]       off1, off2, off3;
  logic [COORD_W-1:0]      cx [3];
  logic [COORD_W-1:0]      cy [3];
  logic [NUM_FACELETS-1:0] flags, hit, flags_nxt;
  rgb_t                    samp [NUM_FACELETS];
  rgb_t                    sel;
  logic [3:0]              idx;
  logic                    done_q, err_q;
  logic                    start_acc, pix_eval, all_full, xfer, last_xfer;

  assign start_acc = Start && (state == IDLE);
  // A pixel arriving with iFrameStart belongs to the new frame: it counts when
  // the frame is just beginning, but in SCAN it marks the end of the old one.
  assign pix_eval  = iPixValid && (((state == WAIT_FRAME) && iFrameStart) ||
                                   ((state == SCAN) && !iFrameStart));
  assign xfer      = (state == EMIT) && oReady;
  assign last_xfer = xfer && (idx == LAST_INDEX);

  facelet_offset_calc #(
    .SIDE_W(SIDE_W)
  ) u_offset (
    .Clk   (Clk),
    .Reset (Reset),
    .load  (start_acc),
    .N     (N),
    .off1  (off1),
    .off2  (off2),
    .off3  (off3)
  );

  // Match the current pixel against every still-empty centre slot.
  always_comb begin
    hit = '0;
    for (int unsigned k = 0; k < NUM_FACELETS; k++) begin
      if (pix_eval && !flags[k] && (iX == cx[k % 3]) && (iY == cy[k / 3]))
        hit[k] = 1'b1;
    end
    flags_nxt = flags | hit;
    all_full  = &flags_nxt;
  end

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and status outputs.
  always_comb begin
    state_nxt = state;
    oValid    = (state == EMIT);
    Busy      = (state != IDLE);
    case (state)
      IDLE:       if (Start) state_nxt = CALC;
      CALC:       state_nxt = WAIT_FRAME;
      WAIT_FRAME: if (iFrameStart) state_nxt = all_full ? EMIT : SCAN;
      SCAN: begin
        if (iFrameStart)   state_nxt = IDLE;
        else if (all_full) state_nxt = EMIT;
      end
      EMIT:       if (last_xfer) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Geometry latch, centre grid and sample capture.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      x_q   <= '0;
      y_q   <= '0;
      flags <= '0;
      for (int unsigned c = 0; c < 3; c++) begin
        cx[c] <= '0;
        cy[c] <= '0;
      end
      for (int unsigned k = 0; k < NUM_FACELETS; k++) samp[k] <= '0;
    end else begin
      flags <= flags_nxt;
      if (start_acc) begin
        x_q   <= CubeX_Start;
        y_q   <= CubeY_Start;
        flags <= '0;
      end
      if (state == CALC) begin
        cx[0] <= x_q + COORD_W'(off1);
        cx[1] <= x_q + COORD_W'(off2);
        cx[2] <= x_q + COORD_W'(off3);
        cy[0] <= y_q + COORD_W'(off1);
        cy[1] <= y_q + COORD_W'(off2);
        cy[2] <= y_q + COORD_W'(off3);
      end
      for (int unsigned k = 0; k < NUM_FACELETS; k++) begin
        if (hit[k]) samp[k] <= '{R: RGB_W'(iR), G: RGB_W'(iG), B: RGB_W'(iB)};
      end
    end
  end

  // Emit index, Done pulse and sticky Error.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      idx    <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= last_xfer;
      if (start_acc) begin
        idx   <= '0;
        err_q <= 1'b0;
      end
      if ((state == SCAN) && iFrameStart) err_q <= 1'b1;
      if (xfer) idx <= last_xfer ? '0 : idx + 4'd1;
    end
  end

  // Output data mux; data is forced to zero outside EMIT.
  always_comb begin
    sel = '0;
    for (int unsigned k = 0; k < NUM_FACELETS; k++) begin
      if (idx == 4'(k)) sel = samp[k];
    end
    oIndex = (state == EMIT) ? idx : '0;
    oR     = (state == EMIT) ? PIX_W'(sel.R) : '0;
    oG     = (state == EMIT) ? PIX_W'(sel.G) : '0;
    oB     = (state == EMIT) ? PIX_W'(sel.B) : '0;
  end

  assign Done  = done_q;
  assign Error = err_q;

endmodule
